// File: rtl/led_cnt_regs_pkg.sv
// led_cnt_regs_pkg: register map, response codes and FSM states for led_cnt_regs
package led_cnt_regs_pkg;
    localparam logic [2:0] REG_DIV     = 3'd0;
    localparam logic [2:0] REG_INT_CLR = 3'd1;
    localparam logic [2:0] REG_INT_CNT = 3'd2;
    localparam logic [2:0] REG_STATUS  = 3'd3;
    localparam logic [2:0] REG_ID      = 3'd4;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int STATUS_LIVE   = 0;
    localparam int STATUS_STICKY = 1;
    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;
endpackage

// File: rtl/led_cnt_pulse_gen.sv
// led_cnt_pulse_gen: registers a one-cycle trigger into a one-cycle output pulse
module led_cnt_pulse_gen (
    input  logic clk,
    input  logic rst,
    input  logic trig_i,
    output logic pulse_o
);
    logic pulse_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pulse_q <= 1'b0;
        else     pulse_q <= trig_i;
    end
    assign pulse_o = pulse_q;
endmodule

// File: rtl/led_cnt_regs.sv
// led_cnt_regs: AXI4-Lite register front end driving the LED counter controls
module led_cnt_regs
    import led_cnt_regs_pkg::*;
#(
    parameter int          ADDR_W   = 5,
    parameter logic [11:0] DIV_RST  = 12'd0,
    parameter logic [31:0] ID_VALUE = 32'h4C45_4430
) (
    input  logic              clk100,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_awaddr,
    input  logic              s_awvalid,
    output logic              s_awready,
    input  logic [31:0]       s_wdata,
    input  logic [3:0]        s_wstrb,
    input  logic              s_wvalid,
    output logic              s_wready,
    output logic [1:0]        s_bresp,
    output logic              s_bvalid,
    input  logic              s_bready,
    input  logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arvalid,
    output logic              s_arready,
    output logic [31:0]       s_rdata,
    output logic [1:0]        s_rresp,
    output logic              s_rvalid,
    input  logic              s_rready,
    output logic [11:0]       div_o,
    output logic              wren_o,
    output logic              int_clr_o,
    input  logic [31:0]       int_cnt_i,
    input  logic              led_int_i
);
    wstate_e     wstate_q, wstate_d;
    rstate_e     rstate_q, rstate_d;
    logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [2:0]  awaddr_q, waddr, raddr;
    logic [11:0] wdata_q, wdata;
    logic [1:0]  wstrb_q, wstrb;
    logic        awready_q, wready_q, arready_q;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic [11:0] div_q, div_d;
    logic        sticky_q, led_q;
    logic        aw_hs, w_hs, ar_hs, commit, div_we, clr_trig, w1c;
    logic        unused_ok;

    assign aw_hs    = s_awvalid & awready_q;
    assign w_hs     = s_wvalid & wready_q;
    assign ar_hs    = s_arvalid & arready_q;
    assign waddr    = aw_held_q ? awaddr_q : s_awaddr[4:2];
    assign wdata    = w_held_q ? wdata_q : s_wdata[11:0];
    assign wstrb    = w_held_q ? wstrb_q : s_wstrb[1:0];
    assign raddr    = s_araddr[4:2];
    // A write commits in the cycle the later of AW/W is (or already was) accepted
    assign commit   = (wstate_q == W_IDLE) & (aw_held_q | aw_hs) & (w_held_q | w_hs);
    assign div_we   = commit & (waddr == REG_DIV) & (|wstrb);
    assign clr_trig = commit & (waddr == REG_INT_CLR) & wstrb[0] & wdata[0];
    assign w1c      = commit & (waddr == REG_STATUS) & wstrb[0] & wdata[STATUS_STICKY];
    assign div_d    = {wstrb[1] ? wdata[11:8] : div_q[11:8], wstrb[0] ? wdata[7:0] : div_q[7:0]};
    assign unused_ok = &{1'b0, s_awaddr[1:0], s_araddr[1:0], s_wdata[31:12], s_wstrb[3:2]};

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q | aw_hs;
        w_held_d  = w_held_q | w_hs;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (commit) begin
            wstate_d  = W_RESP;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (waddr <= REG_ID) ? RESP_OKAY : RESP_SLVERR;
        end else if (wstate_q == W_RESP && s_bready) begin
            wstate_d = W_IDLE;
            bvalid_d = 1'b0;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rstate_d = R_DATA;
            rvalid_d = 1'b1;
            rresp_d  = (raddr <= REG_ID) ? RESP_OKAY : RESP_SLVERR;
            case (raddr)
                REG_DIV:     rdata_d = {20'd0, div_q};
                REG_INT_CNT: rdata_d = int_cnt_i;
                REG_STATUS:  rdata_d = {30'd0, sticky_q, led_int_i};
                REG_ID:      rdata_d = ID_VALUE;
                default:     rdata_d = 32'd0;
            endcase
        end else if (rstate_q == R_DATA && s_rready) begin
            rstate_d = R_IDLE;
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge clk100 or posedge rst) begin
        if (rst) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= 3'd0;
            wdata_q   <= 12'd0;
            wstrb_q   <= 2'd0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            arready_q <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= 32'd0;
            div_q     <= DIV_RST;
            led_q     <= 1'b0;
            sticky_q  <= 1'b0;
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awready_q <= (wstate_d == W_IDLE) & ~aw_held_d;
            wready_q  <= (wstate_d == W_IDLE) & ~w_held_d;
            arready_q <= rstate_d == R_IDLE;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (aw_hs) awaddr_q <= s_awaddr[4:2];
            if (w_hs) begin
                wdata_q <= s_wdata[11:0];
                wstrb_q <= s_wstrb[1:0];
            end
            if (div_we) div_q <= div_d;
            led_q    <= led_int_i;
            // a fresh rising edge outranks a simultaneous W1C
            sticky_q <= (led_int_i & ~led_q) | (sticky_q & ~w1c);
        end
    end

    led_cnt_pulse_gen u_wren (.clk(clk100), .rst(rst), .trig_i(div_we),   .pulse_o(wren_o));
    led_cnt_pulse_gen u_clr  (.clk(clk100), .rst(rst), .trig_i(clr_trig), .pulse_o(int_clr_o));

    assign s_awready = awready_q;
    assign s_wready  = wready_q;
    assign s_bvalid  = bvalid_q;
    assign s_bresp   = bresp_q;
    assign s_arready = arready_q;
    assign s_rvalid  = rvalid_q;
    assign s_rresp   = rresp_q;
    assign s_rdata   = rdata_q;
    assign div_o     = div_q;
endmodule

// File: tb/tb_led_cnt_regs.sv
// tb_led_cnt_regs: directed and randomized AXI-Lite traffic checked against a register-map model
module tb_led_cnt_regs;
    logic        clk100 = 1'b0, rst = 1'b1;
    logic [4:0]  s_awaddr = '0, s_araddr = '0;
    logic        s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
    logic [31:0] s_wdata = '0, int_cnt_i = '0;
    logic [3:0]  s_wstrb = '0;
    logic        led_int_i = 0;
    logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid, wren_o, int_clr_o;
    logic [1:0]  s_bresp, s_rresp;
    logic [31:0] s_rdata;
    logic [11:0] div_o;

    int checks = 0, errors = 0, cyc = 0, n_wren = 0, n_clr = 0;
    int clr_at[$];
    logic [11:0] m_div = 12'd0;
    logic        m_sticky = 1'b0;

    led_cnt_regs dut (
        .clk100(clk100), .rst(rst),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .div_o(div_o), .wren_o(wren_o), .int_clr_o(int_clr_o),
        .int_cnt_i(int_cnt_i), .led_int_i(led_int_i)
    );

    always #5 clk100 = ~clk100;

    always @(negedge clk100) begin
        cyc++;
        if (wren_o) n_wren++;
        if (int_clr_o) begin
            n_clr++;
            clr_at.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a[4:2])
            3'd0:    return 32'(m_div);
            3'd2:    return int_cnt_i;
            3'd3:    return 32'(m_sticky) * 2 + 32'(led_int_i);
            3'd4:    return 32'h4C45_4430;
            default: return 32'd0;
        endcase
    endfunction

    // lead > 0: AW leads W by lead cycles; lead < 0: W leads AW
    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int lead, input bit raise);
        bit aw_done = 0, w_done = 0, af, wf;
        int k = 0, aws, ws;
        aws = lead < 0 ? -lead : 0;
        ws  = lead > 0 ? lead : 0;
        s_awaddr = a; s_wdata = d; s_wstrb = s;
        while (!(aw_done && w_done) && k < 50) begin
            s_awvalid = !aw_done && k >= aws;
            s_wvalid  = !w_done && k >= ws;
            if (raise && k == ws) led_int_i = 1'b1;
            af = s_awvalid & s_awready;
            wf = s_wvalid & s_wready;
            tick();
            aw_done |= af;
            w_done  |= wf;
            k++;
        end
        s_awvalid = 0; s_wvalid = 0;
        chk("wr_handshake", 32'(aw_done && w_done), 1);
        chk("bvalid_lat", s_bvalid, 1);
    endtask

    task automatic wait_b(output logic [1:0] resp);
        resp = s_bresp;
        s_bready = 1;
        tick();
        s_bready = 0;
    endtask

    task automatic rd(input logic [4:0] a);
        bit fire = 0;
        int k = 0;
        logic [31:0] exp;
        s_araddr = a; s_arvalid = 1;
        while (!fire && k < 50) begin
            fire = s_arready;
            exp = model_rd(a);
            tick();
            k++;
        end
        s_arvalid = 0;
        chk("ar_handshake", 32'(fire), 1);
        chk("rvalid_lat", s_rvalid, 1);
        chk("rdata", s_rdata, exp);
        chk("rresp", s_rresp, a[4:2] <= 3'd4 ? 0 : 2);
        s_rready = 1;
        tick();
        s_rready = 0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
        int w0, c0;
        logic [1:0] resp;
        logic [11:0] mask;
        bit exp_wren, exp_clr;
        w0 = n_wren; c0 = n_clr;
        mask = {{4{s[1]}}, {8{s[0]}}};
        exp_wren = a[4:2] == 3'd0 && s[1:0] != 2'd0;
        exp_clr  = a[4:2] == 3'd1 && s[0] && d[0];
        axi_write(a, d, s, lead, 0);
        chk("wren_at_n1", wren_o, 32'(exp_wren));
        chk("intclr_at_n1", int_clr_o, 32'(exp_clr));
        wait_b(resp);
        chk("bresp", resp, a[4:2] <= 3'd4 ? 0 : 2);
        if (a[4:2] == 3'd0) m_div = (m_div & ~mask) | (d[11:0] & mask);
        if (a[4:2] == 3'd3 && s[0] && d[1]) m_sticky = 0;
        chk("div_o", div_o, 32'(m_div));
        tick();
        chk("wren_count", n_wren - w0, 32'(exp_wren));
        chk("clr_count", n_clr - c0, 32'(exp_clr));
    endtask

    initial begin
        int c0, gap, op;
        logic [4:0] a;
        logic [1:0] resp;
        int_cnt_i = 32'h0000_0005;
        repeat (3) tick();
        chk("rst_awready", s_awready, 0);
        chk("rst_arready", s_arready, 0);
        chk("rst_bvalid", s_bvalid, 0);
        chk("rst_rvalid", s_rvalid, 0);
        chk("rst_rdata", s_rdata, 0);
        chk("rst_div", div_o, 0);
        chk("rst_wren", wren_o, 0);
        chk("rst_intclr", int_clr_o, 0);
        rst = 0;
        repeat (2) tick();
        chk("idle_awready", s_awready, 1);
        chk("idle_wready", s_wready, 1);
        chk("idle_arready", s_arready, 1);
        rd(5'h00);
        rd(5'h10);
        rd(5'h08);
        wr(5'h00, 32'h0000_0ABC, 4'hF, 2);
        rd(5'h00);
        wr(5'h00, 32'h0000_0F12, 4'h1, -1);
        chk("div_a12", div_o, 32'h0A12);
        wr(5'h00, 32'h0000_0123, 4'h0, 0);
        wr(5'h00, 32'h0000_0A12, 4'hF, 0);
        s_bready = 1;
        c0 = n_clr;
        clr_at.delete();
        axi_write(5'h04, 32'h1, 4'h1, 0, 0);
        axi_write(5'h04, 32'h1, 4'h1, 0, 0);
        repeat (3) tick();
        s_bready = 0;
        chk("b2b_clr_pulses", n_clr - c0, 2);
        gap = clr_at.size() >= 2 ? clr_at[clr_at.size()-1] - clr_at[clr_at.size()-2] : 0;
        chk("b2b_clr_gap", 32'(gap >= 2), 1);
        rd(5'h04);
        led_int_i = 1; m_sticky = 1;
        repeat (2) tick();
        led_int_i = 0;
        repeat (2) tick();
        rd(5'h0C);
        wr(5'h0C, 32'h2, 4'h1, 0);
        rd(5'h0C);
        axi_write(5'h0C, 32'h2, 4'h1, 1, 1);
        m_sticky = 1;
        wait_b(resp);
        chk("w1c_edge_bresp", resp, 0);
        repeat (2) tick();
        rd(5'h0C);
        chk("status_set_wins", model_rd(5'h0C), 3);
        rd(5'h18);
        wr(5'h18, 32'hFFFF_FFFF, 4'hF, 0);
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 3));
            a  = 5'($urandom_range(0, 31));
            if (op == 0) begin
                int_cnt_i = $urandom;
                rd(a);
            end else if (op == 1) begin
                wr(a, $urandom, 4'($urandom), int'($urandom_range(0, 4)) - 2);
            end else if (op == 2) begin
                led_int_i = ~led_int_i;
                if (led_int_i) m_sticky = 1;
                repeat (2) tick();
            end else begin
                wr(5'($urandom_range(0, 3)) << 2, $urandom, 4'($urandom), int'($urandom_range(0, 2)));
            end
        end
        led_int_i = 0;
        repeat (2) tick();
        axi_write(5'h00, 32'h0000_0555, 4'hF, 0, 0);
        #2 rst = 1;
        #1;
        chk("rst_abort_bvalid", s_bvalid, 0);
        chk("rst_abort_div", div_o, 0);
        chk("rst_abort_wren", wren_o, 0);
        tick();
        rst = 0;
        m_div = 0; m_sticky = 0;
        repeat (4) tick();
        chk("post_rst_bvalid", s_bvalid, 0);
        chk("post_rst_awready", s_awready, 1);
        rd(5'h00);
        rd(5'h0C);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
